// File: rtl/lcd_pattern_pkg.sv
// Shared types for the LCD timing generator: pattern mode encodings,
// RGB565 colour constants and the colour-bar lookup.
package lcd_pattern_pkg;

   typedef enum logic [2:0] {
      MODE_BARS   = 3'd0,
      MODE_WHITE  = 3'd1,
      MODE_CHECK  = 3'd2,
      MODE_RAMP   = 3'd3,
      MODE_BORDER = 3'd4,
      MODE_BLACK  = 3'd5
   } mode_e;

   typedef struct packed {
      logic [4:0] r;
      logic [5:0] g;
      logic [4:0] b;
   } rgb565_t;

   localparam rgb565_t RGB_WHITE = '{r: 5'd31, g: 6'd63, b: 5'd31};
   localparam rgb565_t RGB_BLACK = '{r: 5'd0,  g: 6'd0,  b: 5'd0};

   // Bars walk blue, then green, then red, each channel in powers of two.
   function automatic rgb565_t bar_colour(input logic [3:0] idx);
      rgb565_t c;
      c = RGB_BLACK;
      case (idx)
         4'd0:    c.b = 5'd1;
         4'd1:    c.b = 5'd2;
         4'd2:    c.b = 5'd4;
         4'd3:    c.b = 5'd8;
         4'd4:    c.b = 5'd31;
         4'd5:    c.g = 6'd1;
         4'd6:    c.g = 6'd2;
         4'd7:    c.g = 6'd4;
         4'd8:    c.g = 6'd8;
         4'd9:    c.g = 6'd16;
         4'd10:   c.g = 6'd63;
         4'd11:   c.r = 5'd1;
         4'd12:   c.r = 5'd2;
         4'd13:   c.r = 5'd4;
         4'd14:   c.r = 5'd8;
         default: c.r = 5'd31;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/lcd_pattern_timing_gen_rgb.sv
// Combinational test-pattern colour generator; the border is always drawn
// in unshifted pixel coordinates, the pattern itself uses the scrolled x.
module lcd_pattern_rgb
   import lcd_pattern_pkg::*;
#(
   parameter int H_ACTIVE   = 1024,
   parameter int V_ACTIVE   = 600,
   parameter int CHECK_LOG2 = 5
) (
   input  logic [2:0]  mode,
   input  logic [10:0] x,
   input  logic [10:0] px,
   input  logic [9:0]  py,
   input  logic        de,
   output rgb565_t     rgb
);

   localparam int          BAR_W   = (H_ACTIVE >= 16) ? H_ACTIVE / 16 : 1;
   localparam logic [10:0] BAR_W_L = 11'(BAR_W);
   localparam logic [10:0] X_LAST  = 11'(H_ACTIVE - 1);
   localparam logic [9:0]  Y_LAST  = 10'(V_ACTIVE - 1);

   logic [10:0] bar_raw;
   logic [3:0]  bar_idx;
   logic        border;
   logic        check;

   always_comb begin
      bar_raw = x / BAR_W_L;
      // the last bar absorbs the remainder when H_ACTIVE is not a multiple of 16
      bar_idx = (bar_raw > 11'd15) ? 4'd15 : bar_raw[3:0];
      border  = (px == 11'd0) || (px == X_LAST) || (py == 10'd0) || (py == Y_LAST);
      check   = x[CHECK_LOG2] ^ py[CHECK_LOG2];
      rgb     = RGB_BLACK;
      if (de) begin
         case (mode)
            MODE_BARS:   rgb = border ? RGB_WHITE : bar_colour(bar_idx);
            MODE_WHITE:  rgb = RGB_WHITE;
            MODE_CHECK:  rgb = (border || check) ? RGB_WHITE : RGB_BLACK;
            MODE_RAMP:   rgb = '{r: x[9:5], g: x[9:4], b: x[9:5]};
            MODE_BORDER: rgb = border ? RGB_WHITE : RGB_BLACK;
            default:     rgb = RGB_BLACK;
         endcase
      end
   end

endmodule

// File: rtl/lcd_pattern_timing_gen.sv
// RGB565 parallel-LCD timing generator with test patterns; all outputs are
// registered one cycle after the h/v position. Define LCD_PATTERN_ANIM_EN for scrolling.
module lcd_pattern_timing_gen
   import lcd_pattern_pkg::*;
#(
   parameter int H_ACTIVE    = 1024,
   parameter int H_FP        = 50,
   parameter int H_SYNC      = 1,
   parameter int H_BP        = 50,
   parameter int V_ACTIVE    = 600,
   parameter int V_FP        = 12,
   parameter int V_SYNC      = 3,
   parameter int V_BP        = 20,
   parameter bit SYNC_POL    = 1'b0,
   parameter int CHECK_LOG2  = 5,
   parameter int SCROLL_STEP = 4
) (
   input  logic        PixelClk,
   input  logic        RST,
   input  logic [2:0]  Mode,
   output logic        LCD_DE,
   output logic        LCD_HSYNC,
   output logic        LCD_VSYNC,
   output logic [4:0]  LCD_R,
   output logic [5:0]  LCD_G,
   output logic [4:0]  LCD_B,
   output logic [10:0] PixelX,
   output logic [9:0]  PixelY,
   output logic        FrameStart,
   output logic [15:0] FrameCount
);

   localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

   localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
   localparam logic [11:0] H_SYNC_END = 12'(H_SYNC);
   localparam logic [11:0] H_DE_BEG   = 12'(H_SYNC + H_BP);
   localparam logic [11:0] H_DE_END   = 12'(H_SYNC + H_BP + H_ACTIVE);
   localparam logic [11:0] H_ACT_L    = 12'(H_ACTIVE);
   localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
   localparam logic [10:0] V_SYNC_END = 11'(V_SYNC);
   localparam logic [10:0] V_DE_BEG   = 11'(V_SYNC + V_BP);
   localparam logic [10:0] V_DE_END   = 11'(V_SYNC + V_BP + V_ACTIVE);

   logic [11:0] h_q, h_d;
   logic [10:0] v_q, v_d;
   logic [2:0]  mode_q, mode_d;
   logic [15:0] fc_q, fc_d;
   logic        de_q, de_d;
   logic        hs_q, hs_d;
   logic        vs_q, vs_d;
   logic [10:0] px_q, px_d;
   logic [9:0]  py_q, py_d;
   logic        fs_q, fs_d;
   rgb565_t     rgb_q, rgb_d;

   logic        eol, eof;
   logic        h_act, v_act;
   logic [10:0] offset;
   logic [11:0] x_sum;
   logic [10:0] pat_x;

   always_comb begin
      eol    = (h_q == H_LAST);
      eof    = eol && (v_q == V_LAST);
      h_d    = eol ? 12'd0 : h_q + 12'd1;
      v_d    = v_q;
      if (eol) v_d = eof ? 11'd0 : v_q + 11'd1;
      mode_d = eof ? Mode : mode_q;
      fc_d   = eof ? fc_q + 16'd1 : fc_q;

      h_act  = (h_q >= H_DE_BEG) && (h_q < H_DE_END);
      v_act  = (v_q >= V_DE_BEG) && (v_q < V_DE_END);
      de_d   = h_act && v_act;
      hs_d   = (h_q < H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
      vs_d   = (v_q < V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
      px_d   = de_d ? (h_q[10:0] - H_DE_BEG[10:0]) : 11'd0;
      py_d   = de_d ? (v_q[9:0] - V_DE_BEG[9:0]) : 10'd0;
      fs_d   = de_d && (h_q == H_DE_BEG) && (v_q == V_DE_BEG);

      x_sum  = {1'b0, px_d} + {1'b0, offset};
      pat_x  = (x_sum >= H_ACT_L) ? (x_sum[10:0] - H_ACT_L[10:0]) : x_sum[10:0];
   end

`ifdef LCD_PATTERN_ANIM_EN
   localparam logic [11:0] SCROLL_L = 12'(SCROLL_STEP);

   logic [10:0] offset_q, offset_d;
   logic [11:0] off_sum;

   always_comb begin
      off_sum  = {1'b0, offset_q} + SCROLL_L;
      offset_d = offset_q;
      if (eof) offset_d = (off_sum >= H_ACT_L) ? (off_sum[10:0] - H_ACT_L[10:0]) : off_sum[10:0];
   end

   always_ff @(posedge PixelClk) begin
      if (RST) offset_q <= 11'd0;
      else     offset_q <= offset_d;
   end

   assign offset = offset_q;
`else
   assign offset = 11'd0;
`endif

   lcd_pattern_rgb #(
      .H_ACTIVE   (H_ACTIVE),
      .V_ACTIVE   (V_ACTIVE),
      .CHECK_LOG2 (CHECK_LOG2)
   ) u_rgb (
      .mode (mode_q),
      .x    (pat_x),
      .px   (px_d),
      .py   (py_d),
      .de   (de_d),
      .rgb  (rgb_d)
   );

   always_ff @(posedge PixelClk) begin
      if (RST) begin
         h_q    <= 12'd0;
         v_q    <= 11'd0;
         mode_q <= 3'd0;
         fc_q   <= 16'd0;
         de_q   <= 1'b0;
         hs_q   <= ~SYNC_POL;
         vs_q   <= ~SYNC_POL;
         px_q   <= 11'd0;
         py_q   <= 10'd0;
         fs_q   <= 1'b0;
         rgb_q  <= RGB_BLACK;
      end else begin
         h_q    <= h_d;
         v_q    <= v_d;
         mode_q <= mode_d;
         fc_q   <= fc_d;
         de_q   <= de_d;
         hs_q   <= hs_d;
         vs_q   <= vs_d;
         px_q   <= px_d;
         py_q   <= py_d;
         fs_q   <= fs_d;
         rgb_q  <= rgb_d;
      end
   end

   assign LCD_DE     = de_q;
   assign LCD_HSYNC  = hs_q;
   assign LCD_VSYNC  = vs_q;
   assign LCD_R      = rgb_q.r;
   assign LCD_G      = rgb_q.g;
   assign LCD_B      = rgb_q.b;
   assign PixelX     = px_q;
   assign PixelY     = py_q;
   assign FrameStart = fs_q;
   assign FrameCount = fc_q;

endmodule

// File: tb/tb_lcd_pattern_timing_gen.sv
// Bench for lcd_pattern_timing_gen: a default-size instance for absolute timing
// and bar colours, plus a small SYNC_POL=1 instance for multi-frame behaviour.
module tb_lcd_pattern_timing_gen;

   typedef struct {
      int px;
      int py;
      int r;
      int g;
      int b;
   } vec_t;

   logic clk;
   logic rst_b, rst_s;
   logic [2:0] mode_b, mode_s;

   logic        de_b, hs_b, vs_b, fs_b;
   logic [4:0]  r_b, b_b;
   logic [5:0]  g_b;
   logic [10:0] px_b;
   logic [9:0]  py_b;
   logic [15:0] fc_b;

   logic        de_s, hs_s, vs_s, fs_s;
   logic [4:0]  r_s, b_s;
   logic [5:0]  g_s;
   logic [10:0] px_s;
   logic [9:0]  py_s;
   logic [15:0] fc_s;

   int n_err;
   int n_checks;

   vec_t big_vec[11];
   vec_t small_vec[5];

   lcd_pattern_timing_gen dut_big (
      .PixelClk(clk), .RST(rst_b), .Mode(mode_b),
      .LCD_DE(de_b), .LCD_HSYNC(hs_b), .LCD_VSYNC(vs_b),
      .LCD_R(r_b), .LCD_G(g_b), .LCD_B(b_b),
      .PixelX(px_b), .PixelY(py_b), .FrameStart(fs_b), .FrameCount(fc_b)
   );

   // Small frame: H_TOTAL = 73, V_TOTAL = 43, 3139 cycles per frame.
   lcd_pattern_timing_gen #(
      .H_ACTIVE(64), .H_FP(3), .H_SYNC(2), .H_BP(4),
      .V_ACTIVE(36), .V_FP(2), .V_SYNC(2), .V_BP(3),
      .SYNC_POL(1'b1), .CHECK_LOG2(5), .SCROLL_STEP(4)
   ) dut_small (
      .PixelClk(clk), .RST(rst_s), .Mode(mode_s),
      .LCD_DE(de_s), .LCD_HSYNC(hs_s), .LCD_VSYNC(vs_s),
      .LCD_R(r_s), .LCD_G(g_s), .LCD_B(b_s),
      .PixelX(px_s), .PixelY(py_s), .FrameStart(fs_s), .FrameCount(fc_s)
   );

   always #5 clk = ~clk;

   function automatic int pk(input int r, input int g, input int b);
      return (r << 11) | (g << 5) | b;
   endfunction

   function automatic vec_t mk(input int px, input int py, input int r, input int g, input int b);
      vec_t v;
      v.px = px; v.py = py; v.r = r; v.g = g; v.b = b;
      return v;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic wait_pix_b(input int px, input int py, output bit ok);
      int n;
      n = 0; ok = 0;
      while (!ok && n < 40000) begin
         @(negedge clk);
         n++;
         if (de_b && int'(px_b) == px && int'(py_b) == py) ok = 1;
      end
      if (!ok) begin
         n_checks++; n_err++;
         $display("FAIL wait_big(%0d,%0d): timeout, got no such pixel expected one", px, py);
      end
   endtask

   task automatic wait_pix_s(input int px, input int py, output bit ok);
      int n;
      n = 0; ok = 0;
      while (!ok && n < 4000) begin
         @(negedge clk);
         n++;
         if (de_s && int'(px_s) == px && int'(py_s) == py) ok = 1;
      end
      if (!ok) begin
         n_checks++; n_err++;
         $display("FAIL wait_small(%0d,%0d): timeout, got no such pixel expected one", px, py);
      end
   endtask

   task automatic wait_fs_s(output bit ok);
      int n;
      n = 0; ok = 0;
      while (!ok && n < 4000) begin
         @(negedge clk);
         n++;
         if (fs_s) ok = 1;
      end
      if (!ok) begin
         n_checks++; n_err++;
         $display("FAIL wait_fs_small: timeout, got no FrameStart expected one");
      end
   endtask

   task automatic big_seq();
      int  edge_n, hs_low, vs_low, run, hs_cnt, de_cnt;
      bit  got, stop, ok;
      edge_n = 0; hs_low = 0; vs_low = 0; got = 0;
      while (!got && edge_n < 30000) begin
         @(posedge clk);
         edge_n++;
         @(negedge clk);
         if (de_b) got = 1;
         else begin
            if (!hs_b) hs_low++;
            if (!vs_b) vs_low++;
         end
      end
      check("big_first_de_edge", edge_n, 25927);
      check("big_first_fs", int'(fs_b), 1);
      check("big_first_px", int'(px_b), 0);
      check("big_first_py", int'(py_b), 0);
      check("big_vs_at_de", int'(vs_b), 1);
      check("big_hs_low_pre_de", hs_low, 24);
      check("big_vs_low_pre_de", vs_low, 3375);

      run = 1; stop = 0;
      while (!stop && run < 2000) begin
         @(negedge clk);
         if (de_b) run++;
         else stop = 1;
      end
      check("big_de_run", run, 1024);

      hs_cnt = 0; de_cnt = 0;
      for (int i = 0; i < 1125; i++) begin
         @(negedge clk);
         if (!hs_b) hs_cnt++;
         if (de_b) de_cnt++;
      end
      check("big_hs_low_per_line", hs_cnt, 1);
      check("big_de_per_line", de_cnt, 1024);

      for (int i = 0; i < 11; i++) begin
         wait_pix_b(big_vec[i].px, big_vec[i].py, ok);
         if (ok)
            check($sformatf("big_bar px=%0d", big_vec[i].px),
                  int'({r_b, g_b, b_b}), pk(big_vec[i].r, big_vec[i].g, big_vec[i].b));
      end
   endtask

   task automatic small_seq();
      bit ok;
      int hs_c, vs_c, de_c, fs_c, edge_n, exp60;
      bit got;

      wait_pix_s(0, 0, ok);
      if (ok) begin
         check("s_fs_f0", int'(fs_s), 1);
         check("s_fc_f0", int'(fc_s), 0);
      end
      mode_s = 3'd2;
      wait_pix_s(32, 1, ok);
      if (ok) check("s_mode_held", int'({r_s, g_s, b_s}), pk(0, 8, 0));

      wait_fs_s(ok);
      if (ok) check("s_fc_f1", int'(fc_s), 1);
      for (int i = 0; i < 5; i++) begin
         wait_pix_s(small_vec[i].px, small_vec[i].py, ok);
         if (ok)
            check($sformatf("s_check (%0d,%0d)", small_vec[i].px, small_vec[i].py),
                  int'({r_s, g_s, b_s}), pk(small_vec[i].r, small_vec[i].g, small_vec[i].b));
      end
      mode_s = 3'd7;

      wait_fs_s(ok);
      wait_pix_s(0, 10, ok);
      if (ok) check("s_m7_border", int'({r_s, g_s, b_s}), 0);
      wait_pix_s(10, 10, ok);
      if (ok) check("s_m7_inner", int'({r_s, g_s, b_s}), 0);
      mode_s = 3'd4;

      wait_fs_s(ok);
      if (ok) check("s_fc_f3", int'(fc_s), 3);
      wait_pix_s(5, 5, ok);
      if (ok) check("s_m4_inner", int'({r_s, g_s, b_s}), 0);
      wait_pix_s(63, 5, ok);
      if (ok) check("s_m4_right", int'({r_s, g_s, b_s}), pk(31, 63, 31));
      wait_pix_s(5, 35, ok);
      if (ok) check("s_m4_bottom", int'({r_s, g_s, b_s}), pk(31, 63, 31));
      mode_s = 3'd0;

      // one full frame period starting at a FrameStart sample
      wait_fs_s(ok);
      mode_s = 3'd4;
      hs_c = int'(hs_s); vs_c = int'(vs_s); de_c = int'(de_s); fs_c = int'(fs_s);
      for (int i = 1; i < 3139; i++) begin
         @(negedge clk);
         if (hs_s) hs_c++;
         if (vs_s) vs_c++;
         if (de_s) de_c++;
         if (fs_s) fs_c++;
      end
      check("s_hs_act_per_frame", hs_c, 86);
      check("s_vs_act_per_frame", vs_c, 146);
      check("s_de_per_frame", de_c, 2304);
      check("s_fs_per_frame", fs_c, 1);

      wait_pix_s(10, 3, ok);
      if (ok) check("s_m4_loaded", int'({r_s, g_s, b_s}), 0);

      rst_s = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("s_rst_de", int'(de_s), 0);
      check("s_rst_hs", int'(hs_s), 0);
      check("s_rst_vs", int'(vs_s), 0);
      check("s_rst_rgb", int'({r_s, g_s, b_s}), 0);
      check("s_rst_px", int'(px_s), 0);
      check("s_rst_py", int'(py_s), 0);
      check("s_rst_fs", int'(fs_s), 0);
      check("s_rst_fc", int'(fc_s), 0);
      rst_s = 1'b0;
      mode_s = 3'd0;

      edge_n = 0; got = 0;
      while (!got && edge_n < 1000) begin
         @(posedge clk);
         edge_n++;
         @(negedge clk);
         if (de_s) got = 1;
      end
      check("s_restart_de_edge", edge_n, 372);
      check("s_restart_fs", int'(fs_s), 1);
      wait_pix_s(32, 1, ok);
      if (ok) check("s_restart_mode0", int'({r_s, g_s, b_s}), pk(0, 8, 0));

      for (int f = 0; f < 3; f++) wait_fs_s(ok);
      check("s_fc_after3", int'(fc_s), 3);
`ifdef LCD_PATTERN_ANIM_EN
      exp60 = pk(0, 0, 4);
`else
      exp60 = pk(31, 0, 0);
`endif
      wait_pix_s(60, 5, ok);
      if (ok) check("s_scroll_px60", int'({r_s, g_s, b_s}), exp60);
   endtask

   initial begin
      clk = 1'b0;
      rst_b = 1'b1; rst_s = 1'b1;
      mode_b = 3'd0; mode_s = 3'd0;
      n_err = 0; n_checks = 0;

      big_vec[0]  = mk(0,    5, 31, 63, 31);
      big_vec[1]  = mk(63,   5, 0,  0,  1);
      big_vec[2]  = mk(64,   5, 0,  0,  2);
      big_vec[3]  = mk(200,  5, 0,  0,  8);
      big_vec[4]  = mk(320,  5, 0,  1,  0);
      big_vec[5]  = mk(639,  5, 0,  16, 0);
      big_vec[6]  = mk(640,  5, 0,  63, 0);
      big_vec[7]  = mk(704,  5, 1,  0,  0);
      big_vec[8]  = mk(900,  5, 8,  0,  0);
      big_vec[9]  = mk(1022, 5, 31, 0,  0);
      big_vec[10] = mk(1023, 5, 31, 63, 31);

      small_vec[0] = mk(32, 1,  31, 63, 31);
      small_vec[1] = mk(0,  10, 31, 63, 31);
      small_vec[2] = mk(5,  10, 0,  0,  0);
      small_vec[3] = mk(10, 33, 31, 63, 31);
      small_vec[4] = mk(40, 33, 0,  0,  0);

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_de", int'(de_b), 0);
      check("rst_hs", int'(hs_b), 1);
      check("rst_vs", int'(vs_b), 1);
      check("rst_rgb", int'({r_b, g_b, b_b}), 0);
      check("rst_px", int'(px_b), 0);
      check("rst_py", int'(py_b), 0);
      check("rst_fs", int'(fs_b), 0);
      check("rst_fc", int'(fc_b), 0);
      check("rst_hs_pol1", int'(hs_s), 0);
      check("rst_vs_pol1", int'(vs_s), 0);

      rst_b = 1'b0;
      rst_s = 1'b0;
      fork
         big_seq();
         small_seq();
      join

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/lcd_pattern_timing_gen.md
# lcd_pattern_timing_gen

Parametrised RGB565 parallel-LCD timing generator with built-in test-pattern engine, for the Tang Nano 9K panel path. Generates HSYNC/VSYNC/DE from configurable porch, pulse and active sizes, and exports pixel coordinates and frame strobes for downstream pixel sources. Pattern mode is selectable at run time and changes only at frame boundaries. The block drives the LCD pins directly or feeds a later overlay stage.

## Interface
- H_ACTIVE, 1024, active pixels per line
- H_FP, 50, horizontal front porch (clocks)
- H_SYNC, 1, HSYNC pulse width (clocks, ≥1)
- H_BP, 50, horizontal back porch (clocks)
- V_ACTIVE, 600, active lines per frame
- V_FP, 12, vertical front porch (lines)
- V_SYNC, 3, VSYNC pulse width (lines, ≥1)
- V_BP, 20, vertical back porch (lines)
- SYNC_POL, 0, sync active level (0 = active-low)
- CHECK_LOG2, 5, checkerboard square size = 2^CHECK_LOG2 pixels
- SCROLL_STEP, 4, pixels of horizontal scroll per frame (animation only)
- PixelClk  in  1  pixel clock; sole clock
- RST  in  1  synchronous, active-high reset
- Mode  in  3  pattern select; sampled at frame boundary
- LCD_DE  out  1  data enable
- LCD_HSYNC  out  1  horizontal sync
- LCD_VSYNC  out  1  vertical sync
- LCD_R  out  5  red
- LCD_G  out  6  green
- LCD_B  out  5  blue
- PixelX  out  11  active-area column (0 when DE low)
- PixelY  out  10  active-area row (0 when DE low)
- FrameStart  out  1  one-cycle pulse with first active pixel of frame
- FrameCount  out  16  completed frames, wraps at 65535→0

## Operation
- H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP; V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP.
- Internal h counts 0..H_TOTAL-1; at H_TOTAL-1, h→0 and v increments; v wraps V_TOTAL-1→0.
- HSYNC active for h < H_SYNC; VSYNC active for v < V_SYNC (whole lines).
- DE = h in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) and v in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE).
- PixelX = h−(H_SYNC+H_BP), PixelY = v−(V_SYNC+V_BP) while DE; else 0. RGB = 0 while DE low.
- Mode register mode_q loads Mode when h=H_TOTAL-1 and v=V_TOTAL-1; FrameCount increments at the same point. A mid-frame change of Mode has no effect until the next frame.
- Patterns (x = PixelX + offset, mod H_ACTIVE):
  - 0 colour bars: 16 bars of width H_ACTIVE/16, last bar absorbs remainder; bars 0–4 B=1,2,4,8,31; 5–10 G=1,2,4,8,16,63; 11–15 R=1,2,4,8,31; other channels 0.
  - 1 solid white (31,63,31).
  - 2 checkerboard: white if x[CHECK_LOG2]^PixelY[CHECK_LOG2], else black.
  - 3 grey ramp: R=B=x[9:5], G=x[9:4] (for H_ACTIVE=1024).
  - 4 border: white on PixelX∈{0,H_ACTIVE−1} or PixelY∈{0,V_ACTIVE−1}, else black.
  - 5–7 black.
- Mode 0 and 2 also draw the one-pixel white border of mode 4 on top.

## Timing
- Reset: h=v=0, mode_q=0, FrameCount=0, DE=0, FrameStart=0, RGB=0, PixelX=PixelY=0, syncs at inactive level (~SYNC_POL).
- All outputs registered; outputs at clock edge k after RST deasserts reflect position k−1 (one-cycle latency, all outputs aligned).
- RST asserted mid-frame: reset state on the next edge; timing restarts at h=v=0.
- FrameStart high exactly once per frame, coincident with DE and PixelX=PixelY=0.

## Configuration
- LCD_PATTERN_ANIM_EN defined: offset register adds SCROLL_STEP at each frame boundary, mod H_ACTIVE; patterns scroll left. Border not shifted.
- Undefined: offset fixed at 0; no offset register is synthesised; FrameCount still present.

## Structure
- Package lcd_pattern_pkg: mode encodings (MODE_BARS…MODE_BLACK), RGB565 colour constants, bar value tables.
- Sub-module lcd_pattern_rgb: combinational/registered pattern generator from (mode_q, x, PixelY); timing counters stay in top.

## Test plan
- Defaults, reset released → first DE=1 at edge 25927 (position 23·1125+51) with PixelX=0, PixelY=0, FrameStart=1; DE high exactly 1024 consecutive cycles per line, 600 lines per frame.
- Sync widths: HSYNC low 1 cycle per 1125; VSYNC low 3·1125=3375 cycles per 714375; SYNC_POL=1 inverts both.
- Mode 0: PixelY=5, PixelX=63 → B=1; PixelX=64 → B=2; PixelX=320 → G=1; PixelX=0 → white (border).
- Mode changed 0→2 mid-frame → pattern unchanged until next FrameStart; then PixelX=32, PixelY=1 → white.
- RST pulsed one cycle mid-line → next edge all outputs at reset values; FrameCount=0; timing restarts.
- With LCD_PATTERN_ANIM_EN, mode 0: after 16 frames at PixelX=60, PixelY=5 → bar 1 (B=2); FrameCount=16.
